// File: rtl/usb3_ts_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb3_ts_detect_pkg
// Description : Shared constants for the USB3 training ordered-set receiver.
//               Symbol values, alignment FSM encodings, the TS2 link-config
//               Reset bit index and a COM-word detect helper.
// Revision    : 1.0  initial release
// ============================================================================
package usb3_ts_detect_pkg;

    // Symbol constants
    localparam logic [7:0] c_SYM_COM    = 8'hBC;
    localparam logic [7:0] c_SYM_TS1_ID = 8'h4A;
    localparam logic [7:0] c_SYM_TS2_ID = 8'h45;

    // Alignment FSM encodings
    localparam logic [1:0] c_TSD_HUNT = 2'd0;
    localparam logic [1:0] c_TSD_W1   = 2'd1;
    localparam logic [1:0] c_TSD_W2   = 2'd2;
    localparam logic [1:0] c_TSD_W3   = 2'd3;

    // Reset request bit inside the TS2 link configuration symbol
    localparam int c_TS2_CFG_RESET = 0;

    // A full COM word: four K-coded 0xBC symbols
    function automatic logic is_com_word(input logic [31:0] data,
                                         input logic [3:0]  datak);
        return (datak == 4'hF) && (data == {4{c_SYM_COM}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb3_idle_count.sv
`default_nettype none
// ============================================================================
// Module      : usb3_idle_count
// Description : Logical-idle exit counter for Polling.Idle / Recovery.Idle.
//               irc counts consecutive idle words (saturating), itc starts on
//               the first idle word and counts every cycle (saturating).
//               o_train_idle_pass latches once both are saturated and holds
//               until i_train_idle falls.
// Ports       : local_clk          in   clock
//               reset              in   asynchronous active-high reset
//               i_rx_data[31:0]    in   descrambled RX word
//               i_rx_datak[3:0]    in   K flags
//               i_rx_valid         in   word qualifier
//               i_train_idle       in   LTSSM in an Idle substate
//               o_train_idle_pass  out  idle exit criterion met (level)
// Revision    : 1.0  initial release
// ============================================================================
module usb3_idle_count #(
    parameter int IDLE_RX_WORDS = 2,
    parameter int IDLE_TX_WORDS = 4
) (
    input  logic        local_clk,
    input  logic        reset,
    input  logic [31:0] i_rx_data,
    input  logic [3:0]  i_rx_datak,
    input  logic        i_rx_valid,
    input  logic        i_train_idle,
    output logic        o_train_idle_pass
);

    localparam int c_IRC_W = $clog2(IDLE_RX_WORDS + 1);
    localparam int c_ITC_W = $clog2(IDLE_TX_WORDS + 1);
    localparam logic [c_IRC_W-1:0] c_IRC_MAX = c_IRC_W'(IDLE_RX_WORDS);
    localparam logic [c_ITC_W-1:0] c_ITC_MAX = c_ITC_W'(IDLE_TX_WORDS);
    localparam logic [c_ITC_W-1:0] c_ITC_ONE = c_ITC_W'(1);

    logic [c_IRC_W-1:0] r_irc;
    logic [c_ITC_W-1:0] r_itc;
    logic               r_pass;

    logic w_idle_word;
    logic w_busy_word;
    logic w_irc_sat;
    logic w_itc_sat;

    assign w_idle_word = i_rx_valid && (i_rx_data == 32'h0) && (i_rx_datak == 4'h0);
    assign w_busy_word = i_rx_valid && !w_idle_word;
    assign w_irc_sat   = (r_irc == c_IRC_MAX);
    assign w_itc_sat   = (r_itc == c_ITC_MAX);

    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            r_irc  <= '0;
            r_itc  <= '0;
            r_pass <= 1'b0;
        end else if (!i_train_idle) begin
            r_irc  <= '0;
            r_itc  <= '0;
            r_pass <= 1'b0;
        end else begin
            // Uses the counter values from the previous edge, so pass lands
            // one cycle after both counters saturate and survives a clear.
            r_pass <= r_pass | (w_irc_sat & w_itc_sat);
            if (w_busy_word) begin
                r_irc <= '0;
                r_itc <= '0;
            end else begin
                if (w_idle_word && !w_irc_sat) begin
                    r_irc <= r_irc + 1'b1;
                end
                // itc is nonzero only while a run is in progress; it keeps
                // counting through rx_valid gaps.
                if (r_itc != '0) begin
                    if (!w_itc_sat) begin
                        r_itc <= r_itc + 1'b1;
                    end
                end else if (w_idle_word) begin
                    r_itc <= c_ITC_ONE;
                end
            end
        end
    end

    assign o_train_idle_pass = r_pass;

endmodule
`default_nettype wire

// File: rtl/usb3_ts_detect.sv
`default_nettype none
// ============================================================================
// Module      : usb3_ts_detect
// Description : Training ordered-set receiver. Word-aligns and validates
//               TS1/TS2 ordered sets (COM word + three body words), reports
//               malformed sets, captures the TS2 link configuration symbol,
//               and counts logical idle for the LTSSM idle exit.
//               Optional macro USB3_TS_HOTRESET_EN enables hot_reset
//               detection (two consecutive TS2s with the Reset bit set);
//               without it hot_reset is tied low.
// Ports       : local_clk          in   PIPE-side clock
//               reset              in   asynchronous active-high reset
//               rx_data[31:0]      in   descrambled RX word, byte[7:0] first
//               rx_datak[3:0]      in   K flag per byte
//               rx_valid           in   word qualifier
//               train_idle         in   LTSSM in Polling.Idle/Recovery.Idle
//               train_ts1          out  pulse per valid TS1
//               train_ts2          out  pulse per valid TS2
//               ts_link_cfg[7:0]   out  link config of last valid TS2
//               ts_err             out  pulse per malformed ordered set
//               train_idle_pass    out  idle exit criterion met (level)
//               hot_reset          out  TS2 Reset bit seen (level)
// Revision    : 1.0  initial release
// ============================================================================
module usb3_ts_detect
    import usb3_ts_detect_pkg::*;
#(
    parameter int IDLE_RX_WORDS = 2,
    parameter int IDLE_TX_WORDS = 4
) (
    input  logic        local_clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic        rx_valid,
    input  logic        train_idle,
    output logic        train_ts1,
    output logic        train_ts2,
    output logic [7:0]  ts_link_cfg,
    output logic        ts_err,
    output logic        train_idle_pass,
    output logic        hot_reset
);

    logic [1:0] r_state;
    logic [7:0] r_id;
    logic [7:0] r_cfg;
    logic       r_train_ts1;
    logic       r_train_ts2;
    logic       r_ts_err;
    logic [7:0] r_ts_link_cfg;

    logic w_com;
    logic w_w1_ok;
    logic w_body_ok;

    assign w_com = is_com_word(rx_data, rx_datak);

    // w1: byte0 = 0x00, bytes 2/3 equal and a known TS identifier
    assign w_w1_ok = (rx_datak == 4'h0) &&
                     (rx_data[7:0] == 8'h00) &&
                     (rx_data[23:16] == rx_data[31:24]) &&
                     ((rx_data[23:16] == c_SYM_TS1_ID) ||
                      (rx_data[23:16] == c_SYM_TS2_ID));

    assign w_body_ok = (rx_datak == 4'h0) && (rx_data == {4{r_id}});

    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_TSD_HUNT;
            r_id          <= 8'h00;
            r_cfg         <= 8'h00;
            r_train_ts1   <= 1'b0;
            r_train_ts2   <= 1'b0;
            r_ts_err      <= 1'b0;
            r_ts_link_cfg <= 8'h00;
        end else begin
            r_train_ts1 <= 1'b0;
            r_train_ts2 <= 1'b0;
            r_ts_err    <= 1'b0;
            case (r_state)
                c_TSD_HUNT: begin
                    if (rx_valid && w_com) begin
                        r_state <= c_TSD_W1;
                    end
                end
                c_TSD_W1: begin
                    if (!rx_valid) begin
                        r_state <= c_TSD_HUNT;
                    end else if (w_com) begin
                        // Resync: this COM word becomes the new w0
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_W1;
                    end else if (w_w1_ok) begin
                        r_id    <= rx_data[23:16];
                        r_cfg   <= rx_data[15:8];
                        r_state <= c_TSD_W2;
                    end else begin
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_HUNT;
                    end
                end
                c_TSD_W2: begin
                    if (!rx_valid) begin
                        r_state <= c_TSD_HUNT;
                    end else if (w_com) begin
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_W1;
                    end else if (w_body_ok) begin
                        r_state <= c_TSD_W3;
                    end else begin
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_HUNT;
                    end
                end
                c_TSD_W3: begin
                    if (!rx_valid) begin
                        r_state <= c_TSD_HUNT;
                    end else if (w_com) begin
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_W1;
                    end else if (w_body_ok) begin
                        r_state <= c_TSD_HUNT;
                        if (r_id == c_SYM_TS2_ID) begin
                            r_train_ts2   <= 1'b1;
                            r_ts_link_cfg <= r_cfg;
                        end else begin
                            r_train_ts1 <= 1'b1;
                        end
                    end else begin
                        r_ts_err <= 1'b1;
                        r_state  <= c_TSD_HUNT;
                    end
                end
                default: begin
                    r_state <= c_TSD_HUNT;
                end
            endcase
        end
    end

    assign train_ts1   = r_train_ts1;
    assign train_ts2   = r_train_ts2;
    assign ts_err      = r_ts_err;
    assign ts_link_cfg = r_ts_link_cfg;

`ifdef USB3_TS_HOTRESET_EN
    // Evaluated from the registered TS pulses, so hot_reset moves one cycle
    // after the TS pulse that causes it.
    logic r_ts2_run;
    logic r_hot_reset;

    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            r_ts2_run   <= 1'b0;
            r_hot_reset <= 1'b0;
        end else if (r_train_ts2) begin
            if (r_ts_link_cfg[c_TS2_CFG_RESET]) begin
                if (r_ts2_run) begin
                    r_hot_reset <= 1'b1;
                end
                r_ts2_run <= 1'b1;
            end else begin
                r_ts2_run   <= 1'b0;
                r_hot_reset <= 1'b0;
            end
        end else if (r_train_ts1) begin
            r_ts2_run   <= 1'b0;
            r_hot_reset <= 1'b0;
        end
    end

    assign hot_reset = r_hot_reset;
`else
    assign hot_reset = 1'b0;
`endif

    usb3_idle_count #(
        .IDLE_RX_WORDS (IDLE_RX_WORDS),
        .IDLE_TX_WORDS (IDLE_TX_WORDS)
    ) u_idle_count (
        .local_clk         (local_clk),
        .reset             (reset),
        .i_rx_data         (rx_data),
        .i_rx_datak        (rx_datak),
        .i_rx_valid        (rx_valid),
        .i_train_idle      (train_idle),
        .o_train_idle_pass (train_idle_pass)
    );

endmodule
`default_nettype wire

// File: tb/tb_usb3_ts_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb3_ts_detect
// Description : Self-checking bench for usb3_ts_detect. A queue-based model of
//               ordered-set reception and an arithmetic model of the idle exit
//               rule are compared with the DUT on every cycle; directed tests
//               add hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_usb3_ts_detect;

    localparam int RXW = 2;
    localparam int TXW = 4;
`ifdef USB3_TS_HOTRESET_EN
    localparam bit HOT_EN = 1'b1;
`else
    localparam bit HOT_EN = 1'b0;
`endif
    localparam logic [7:0] TS1 = 8'h4A;
    localparam logic [7:0] TS2 = 8'h45;
    localparam logic [31:0] COMW = 32'hBCBC_BCBC;

    logic        local_clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [3:0]  rx_datak;
    logic        rx_valid;
    logic        train_idle;
    logic        train_ts1;
    logic        train_ts2;
    logic [7:0]  ts_link_cfg;
    logic        ts_err;
    logic        train_idle_pass;
    logic        hot_reset;

    usb3_ts_detect #(
        .IDLE_RX_WORDS (RXW),
        .IDLE_TX_WORDS (TXW)
    ) dut (
        .local_clk       (local_clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_datak        (rx_datak),
        .rx_valid        (rx_valid),
        .train_idle      (train_idle),
        .train_ts1       (train_ts1),
        .train_ts2       (train_ts2),
        .ts_link_cfg     (ts_link_cfg),
        .ts_err          (ts_err),
        .train_idle_pass (train_idle_pass),
        .hot_reset       (hot_reset)
    );

    always #5 local_clk = ~local_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] cand[$];        // words of the ordered set collected so far
    bit          exp_ts1, exp_ts2, exp_err, exp_pass, exp_hot;
    logic [7:0]  exp_cfg;
    int          trail;          // trailing run of TS2s carrying the Reset bit
    int          edge_no;
    bit          run_active;
    int          run_start, n_idle, sat_edge;
    bit          sat_valid;
    bit          m_ok;
    bit          idle_cond;
    logic [7:0]  m_id;

    always @(posedge local_clk or posedge reset) begin
        if (reset) begin
            cand.delete();
            exp_ts1 = 0; exp_ts2 = 0; exp_err = 0; exp_pass = 0; exp_hot = 0;
            exp_cfg = 8'h00; trail = 0; run_active = 0; sat_valid = 0;
        end else begin
            edge_no++;
            exp_hot = HOT_EN && (trail >= 2);
            exp_ts1 = 0; exp_ts2 = 0; exp_err = 0;
            if (!rx_valid) begin
                cand.delete();
            end else if (rx_datak == 4'hF && rx_data == COMW) begin
                if (cand.size() != 0) exp_err = 1;
                cand.delete();
                cand.push_back(rx_data);
            end else if (cand.size() != 0) begin
                m_ok = (rx_datak == 4'h0);
                if (cand.size() == 1) begin
                    m_ok = m_ok && (rx_data[7:0] == 8'h00) && (rx_data[31:24] == rx_data[23:16]) &&
                           (rx_data[23:16] == TS1 || rx_data[23:16] == TS2);
                end else begin
                    m_id = cand[1][23:16];
                    m_ok = m_ok && (rx_data == {m_id, m_id, m_id, m_id});
                end
                if (!m_ok) begin
                    exp_err = 1;
                    cand.delete();
                end else begin
                    cand.push_back(rx_data);
                    if (cand.size() == 4) begin
                        if (cand[1][23:16] == TS2) begin
                            exp_ts2 = 1;
                            exp_cfg = cand[1][15:8];
                            trail   = exp_cfg[0] ? trail + 1 : 0;
                        end else begin
                            exp_ts1 = 1;
                            trail   = 0;
                        end
                        cand.delete();
                    end
                end
            end
            // idle: pass once RXW consecutive idle words and TXW cycles since
            // the first idle word have both elapsed, one cycle later
            idle_cond = run_active && sat_valid && (sat_edge <= edge_no - 1) &&
                        (run_start + TXW - 1 <= edge_no - 1);
            if (!train_idle) begin
                run_active = 0;
                exp_pass   = 0;
            end else begin
                if (idle_cond) exp_pass = 1;
                if (rx_valid && rx_data == 32'h0 && rx_datak == 4'h0) begin
                    if (!run_active) begin
                        run_active = 1; run_start = edge_no; n_idle = 0; sat_valid = 0;
                    end
                    n_idle++;
                    if (!sat_valid && n_idle >= RXW) begin
                        sat_valid = 1; sat_edge = edge_no;
                    end
                end else if (rx_valid) begin
                    run_active = 0;
                end
            end
        end
    end

    always @(posedge local_clk) cyc++;

    // ---------------- per-cycle compare and pulse log ----------------
    int ts1_q[$];
    int ts2_q[$];
    int err_q[$];

    always @(negedge local_clk) begin
        if (train_ts1 === 1'b1) ts1_q.push_back(cyc);
        if (train_ts2 === 1'b1) ts2_q.push_back(cyc);
        if (ts_err === 1'b1)    err_q.push_back(cyc);
        if (chk_en) begin
            chk("cyc_train_ts1", 32'(train_ts1), 32'(exp_ts1));
            chk("cyc_train_ts2", 32'(train_ts2), 32'(exp_ts2));
            chk("cyc_ts_err", 32'(ts_err), 32'(exp_err));
            chk("cyc_ts_link_cfg", 32'(ts_link_cfg), 32'(exp_cfg));
            chk("cyc_train_idle_pass", 32'(train_idle_pass), 32'(exp_pass));
            chk("cyc_hot_reset", 32'(hot_reset), 32'(exp_hot));
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [31:0] d, input logic [3:0] k, input logic v);
        rx_data = d; rx_datak = k; rx_valid = v;
        @(posedge local_clk);
        #1;
    endtask

    task automatic send_ts(input logic [7:0] id, input logic [7:0] cfg);
        put(COMW, 4'hF, 1'b1);
        put({id, id, cfg, 8'h00}, 4'h0, 1'b1);
        put({id, id, id, id}, 4'h0, 1'b1);
        put({id, id, id, id}, 4'h0, 1'b1);
    endtask

    task automatic clear_logs();
        ts1_q.delete(); ts2_q.delete(); err_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ts1"}, 32'(train_ts1), 32'd0);
        chk({tag, "_ts2"}, 32'(train_ts2), 32'd0);
        chk({tag, "_err"}, 32'(ts_err), 32'd0);
        chk({tag, "_cfg"}, 32'(ts_link_cfg), 32'd0);
        chk({tag, "_pass"}, 32'(train_idle_pass), 32'd0);
        chk({tag, "_hot"}, 32'(hot_reset), 32'd0);
    endtask

    int com_edge;
    int d;

    initial begin
        rx_data = 32'h0; rx_datak = 4'h0; rx_valid = 1'b0; train_idle = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge local_clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        chk_all_zero("reset");

        // Eight back-to-back TS1s: 8 pulses, 4 cycles apart, no errors
        clear_logs();
        repeat (8) send_ts(TS1, 8'h00);
        put(32'h0, 4'h0, 1'b0);
        chk("b2b_ts1_count", 32'(ts1_q.size()), 32'd8);
        chk("b2b_err_count", 32'(err_q.size()), 32'd0);
        for (int i = 1; i < ts1_q.size(); i++)
            chk("b2b_ts1_spacing", 32'(ts1_q[i] - ts1_q[i-1]), 32'd4);

        // Two TS2 with Reset bit, then a TS1
        send_ts(TS2, 8'h01);
        send_ts(TS2, 8'h01);
        chk("ts2_cfg", 32'(ts_link_cfg), 32'h01);
        chk("hot_at_pulse", 32'(hot_reset), 32'd0);
        put(32'h0, 4'h0, 1'b0);
        chk("hot_after_2nd_ts2", 32'(hot_reset), 32'(HOT_EN));
        send_ts(TS1, 8'h00);
        put(32'h0, 4'h0, 1'b0);
        chk("hot_clr_by_ts1", 32'(hot_reset), 32'd0);

        // TS1 with a corrupted w2 byte2, then a good TS1
        clear_logs();
        put(COMW, 4'hF, 1'b1);
        put({TS1, TS1, 8'h00, 8'h00}, 4'h0, 1'b1);
        put({TS1, TS2, TS1, TS1}, 4'h0, 1'b1);
        put({TS1, TS1, TS1, TS1}, 4'h0, 1'b1);
        put(32'h0, 4'h0, 1'b0);
        chk("bad_w2_err", 32'(err_q.size()), 32'd1);
        chk("bad_w2_no_ts1", 32'(ts1_q.size()), 32'd0);
        send_ts(TS1, 8'h00);
        put(32'h0, 4'h0, 1'b0);
        chk("good_after_bad_ts1", 32'(ts1_q.size()), 32'd1);

        // Malformed w1 (byte0 nonzero)
        clear_logs();
        put(COMW, 4'hF, 1'b1);
        put({TS2, TS2, 8'h01, 8'h07}, 4'h0, 1'b1);
        put(32'h0, 4'h0, 1'b0);
        chk("bad_w1_err", 32'(err_q.size()), 32'd1);

        // COM injected at W2, then a full TS2 body
        clear_logs();
        put(COMW, 4'hF, 1'b1);
        put({TS2, TS2, 8'h00, 8'h00}, 4'h0, 1'b1);
        com_edge = cyc + 1;
        put(COMW, 4'hF, 1'b1);
        put({TS2, TS2, 8'h5A, 8'h00}, 4'h0, 1'b1);
        put({TS2, TS2, TS2, TS2}, 4'h0, 1'b1);
        put({TS2, TS2, TS2, TS2}, 4'h0, 1'b1);
        put(32'h0, 4'h0, 1'b0);
        chk("resync_err_count", 32'(err_q.size()), 32'd1);
        chk("resync_ts2_count", 32'(ts2_q.size()), 32'd1);
        d = (ts2_q.size() > 0) ? ts2_q[0] - com_edge : -1;
        chk("resync_ts2_latency", 32'(d), 32'd3);
        chk("resync_cfg", 32'(ts_link_cfg), 32'h5A);

        // rx_valid dropped at W1: body words that follow must be ignored
        clear_logs();
        put(COMW, 4'hF, 1'b1);
        put(32'h0, 4'h0, 1'b0);
        put({TS1, TS1, 8'h00, 8'h00}, 4'h0, 1'b1);
        put({TS1, TS1, TS1, TS1}, 4'h0, 1'b1);
        put({TS1, TS1, TS1, TS1}, 4'h0, 1'b1);
        put(32'h0, 4'h0, 1'b0);
        chk("drop_w1_no_ts1", 32'(ts1_q.size()), 32'd0);
        chk("drop_w1_no_err", 32'(err_q.size()), 32'd0);

        // Reset asserted while w3 is on the bus
        put(COMW, 4'hF, 1'b1);
        put({TS2, TS2, 8'h03, 8'h00}, 4'h0, 1'b1);
        put({TS2, TS2, TS2, TS2}, 4'h0, 1'b1);
        chk("cfg_before_rst", 32'(ts_link_cfg), 32'h5A);
        rx_data = {TS2, TS2, TS2, TS2}; rx_datak = 4'h0; rx_valid = 1'b1;
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        @(posedge local_clk);
        #1 reset = 1'b0;
        rx_valid = 1'b0;
        put(32'h0, 4'h0, 1'b0);

        // Idle exit: pass on the 5th cycle after the first idle word
        train_idle = 1'b1;
        repeat (4) put(32'h0, 4'h0, 1'b1);
        chk("idle_pass_cycle4", 32'(train_idle_pass), 32'd0);
        put(32'h0, 4'h0, 1'b1);
        chk("idle_pass_cycle5", 32'(train_idle_pass), 32'd1);
        put(32'h0000_0100, 4'h0, 1'b1);
        chk("idle_pass_holds", 32'(train_idle_pass), 32'd1);
        train_idle = 1'b0;
        put(32'h0, 4'h0, 1'b0);
        chk("idle_pass_drop", 32'(train_idle_pass), 32'd0);

        // Nonzero word at idle word 2 restarts the count
        train_idle = 1'b1;
        put(32'h0, 4'h0, 1'b1);
        put(32'h0000_0100, 4'h0, 1'b1);
        repeat (4) put(32'h0, 4'h0, 1'b1);
        chk("restart_pass_cycle4", 32'(train_idle_pass), 32'd0);
        put(32'h0, 4'h0, 1'b1);
        chk("restart_pass_cycle5", 32'(train_idle_pass), 32'd1);
        train_idle = 1'b0;
        put(32'h0, 4'h0, 1'b0);
        chk("restart_pass_drop", 32'(train_idle_pass), 32'd0);

        repeat (2) put(32'h0, 4'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
